// File: rtl/mac_feeder.sv
// mac_feeder: buffers operand pairs in a small FIFO and sequences a downstream
// MAC (clear, prime, stream, drain) to compute a dot product of len pairs.
module mac_feeder #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 8,
   parameter int LEN_WIDTH  = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [LEN_WIDTH-1:0]    len,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_WIDTH-1:0]   in_a,
   input  logic [DATA_WIDTH-1:0]   in_b,
   output logic                    mac_en,
   output logic                    mac_clr,
   output logic [DATA_WIDTH-1:0]   mac_a,
   output logic [DATA_WIDTH-1:0]   mac_b,
   input  logic [3*DATA_WIDTH-1:0] mac_cout,
   output logic                    busy,
   output logic                    done,
   output logic [3*DATA_WIDTH-1:0] result
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_PRIME, S_STREAM, S_DRAIN, S_DONE
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;

   // Operand storage; pointers carry one extra bit to tell full from empty.
   logic [DATA_WIDTH-1:0] r_mem_a [DEPTH];
   logic [DATA_WIDTH-1:0] r_mem_b [DEPTH];
   logic [AW:0]           r_wr_ptr;
   logic [AW:0]           r_rd_ptr;

   logic [LEN_WIDTH-1:0]  r_len;
   logic [LEN_WIDTH-1:0]  r_cnt;
   logic [LEN_WIDTH-1:0]  w_cnt_nxt;

   logic                  w_empty;
   logic                  w_full;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_load_job;
   logic                  w_zero_result;
   logic                  w_capture;
   logic                  w_cnt_inc;

   assign w_empty   = (r_wr_ptr == r_rd_ptr);
   assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign in_ready  = rst_n && !w_full;
   assign w_push    = in_valid && in_ready;
   // Count never exceeds len, so the increment cannot wrap.
   assign w_cnt_nxt = r_cnt + LEN_WIDTH'(1);

   assign busy = (r_state != S_IDLE);
   assign done = (r_state == S_DONE);

   // Operand write port; storage needs no reset since pointers define validity.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_a[r_wr_ptr[AW-1:0]] <= in_a;
         r_mem_b[r_wr_ptr[AW-1:0]] <= in_b;
      end
   end

   // Control state: FSM, FIFO pointers, job length, element count, result.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_len    <= '0;
         r_cnt    <= '0;
         result   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_push)
            r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
         if (w_load_job) begin
            r_len <= len;
            r_cnt <= '0;
         end else if (w_cnt_inc) begin
            r_cnt <= w_cnt_nxt;
         end
         if (w_zero_result)
            result <= '0;
         else if (w_capture)
            result <= mac_cout;
      end
   end

   // Next-state and MAC drive; operands only leave the FIFO in STREAM.
   always_comb begin
      w_state_nxt   = r_state;
      w_pop         = 1'b0;
      w_load_job    = 1'b0;
      w_zero_result = 1'b0;
      w_capture     = 1'b0;
      w_cnt_inc     = 1'b0;
      mac_en        = 1'b0;
      mac_clr       = 1'b0;
      mac_a         = '0;
      mac_b         = '0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               if (len != '0) begin
                  w_load_job  = 1'b1;
                  w_state_nxt = S_CLEAR;
               end else begin
                  w_zero_result = 1'b1;
                  w_state_nxt   = S_DONE;
               end
            end
         end
         S_CLEAR: begin
            mac_clr     = 1'b1;
            w_state_nxt = S_PRIME;
         end
         S_PRIME: begin
            // Enable without data moves the MAC into its accumulate state.
            if (!w_empty) begin
               mac_en      = 1'b1;
               w_state_nxt = S_STREAM;
            end
         end
         S_STREAM: begin
            if (!w_empty) begin
               w_pop     = 1'b1;
               w_cnt_inc = 1'b1;
               mac_en    = 1'b1;
               mac_a     = r_mem_a[r_rd_ptr[AW-1:0]];
               mac_b     = r_mem_b[r_rd_ptr[AW-1:0]];
               if (w_cnt_nxt == r_len)
                  w_state_nxt = S_DRAIN;
            end else begin
               // Underflow drops the MAC back to idle, so it must be re-primed.
               w_state_nxt = S_PRIME;
            end
         end
         S_DRAIN: begin
            w_capture   = 1'b1;
            w_state_nxt = S_DONE;
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mac_feeder.sv
// Testbench for mac_feeder: behavioural downstream MAC, scoreboard of expected
// job results checked by a monitor on every done pulse.
module tb_mac_feeder;

   localparam int DW = 8;
   localparam int DP = 8;
   localparam int LW = 8;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            start;
   logic [LW-1:0]   len;
   logic            in_valid;
   logic            in_ready;
   logic [DW-1:0]   in_a;
   logic [DW-1:0]   in_b;
   logic            mac_en;
   logic            mac_clr;
   logic [DW-1:0]   mac_a;
   logic [DW-1:0]   mac_b;
   logic [3*DW-1:0] mac_cout;
   logic            busy;
   logic            done;
   logic [3*DW-1:0] result;

   mac_feeder #(.DATA_WIDTH(DW), .DEPTH(DP), .LEN_WIDTH(LW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .len(len),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .mac_en(mac_en), .mac_clr(mac_clr), .mac_a(mac_a), .mac_b(mac_b),
      .mac_cout(mac_cout), .busy(busy), .done(done), .result(result)
   );

   always #5 clk = ~clk;

   // Downstream MAC: Clr zeroes; first En cycle primes, later En cycles add.
   logic [3*DW-1:0] m_acc = '0;
   logic            m_armed = 1'b0;
   assign mac_cout = m_acc;
   always @(posedge clk) begin
      if (mac_clr) begin
         m_acc   <= '0;
         m_armed <= 1'b0;
      end else if (mac_en) begin
         if (m_armed)
            m_acc <= m_acc + (3*DW)'(mac_a) * (3*DW)'(mac_b);
         m_armed <= 1'b1;
      end else begin
         m_armed <= 1'b0;
      end
   end

   typedef struct {
      logic [3*DW-1:0] res;
      int              lat;
      int              en;
      int              clr;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: per-job enable/clear counts, latency, result on done.
   int mon_start = 0;
   int mon_en    = 0;
   int mon_clr   = 0;
   always @(negedge clk) begin
      if (!rst_n) begin
         mon_en  = 0;
         mon_clr = 0;
      end else begin
         if (start && !busy) begin
            mon_start = cyc;
            mon_en    = 0;
            mon_clr   = 0;
         end
         if (mac_en)  mon_en++;
         if (mac_clr) mon_clr++;
         if (!mac_en && (mac_a != '0 || mac_b != '0))
            chk("mac_ab_zero_when_idle", {mac_a, mac_b}, 0);
         if (done) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("result", result, e.res);
               if (e.lat >= 0) chk("done_latency", cyc - mon_start, e.lat);
               chk("mac_en_cycles", mon_en, e.en);
               chk("mac_clr_cycles", mon_clr, e.clr);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [DW-1:0] a, input logic [DW-1:0] b);
      int k;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      k = 0;
      while (!in_ready && k < 200) begin
         tick();
         k++;
      end
      if (k == 200) chk("push_timeout", 1, 0);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while (busy && k < 600) begin
         tick();
         k++;
      end
      if (k == 600) chk("idle_timeout", 1, 0);
   endtask

   task automatic start_job(input int l, input logic [3*DW-1:0] r,
                            input int lat, input int en, input int clr);
      exp_t e;
      e.res = r; e.lat = lat; e.en = en; e.clr = clr;
      sb.push_back(e);
      start = 1'b1;
      len   = LW'(l);
      tick();
      start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      rst_n = 1'b0; start = 1'b0; len = '0;
      in_valid = 1'b0; in_a = '0; in_b = '0;
      tick();
      tick();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_result", result, 0);
      chk("rst_mac_en_clr", {mac_en, mac_clr}, 0);
      rst_n = 1'b1;
      tick();
      chk("idle_in_ready", in_ready, 1);

      // Pre-filled FIFO, len=3; a mid-job start with len=0 must be ignored.
      push(2, 3); push(4, 5); push(1, 7);
      start_job(3, 33, 7, 4, 1);
      start = 1'b1; len = '0;
      tick();
      start = 1'b0;
      wait_idle();

      // Underflow gap after two pairs forces a second prime.
      push(2, 3); push(4, 5);
      start_job(3, 33, -1, 5, 1);
      repeat (5) tick();
      push(1, 7);
      wait_idle();

      // Zero-length job completes on the next cycle without touching the MAC.
      start_job(0, 0, 1, 0, 0);
      wait_idle();

      // Saturated operands, then a short job to confirm the clear between jobs.
      for (int i = 0; i < 4; i++) push(255, 255);
      start_job(4, 260100, 8, 5, 1);
      wait_idle();
      push(3, 3);
      start_job(1, 9, 5, 2, 1);
      wait_idle();

      // Backpressure: eight accepts fill the FIFO, ninth waits for a pop.
      for (int i = 0; i < 8; i++) push(1, 1);
      in_valid = 1'b1; in_a = 2; in_b = 2;
      chk("full_in_ready", in_ready, 0);
      tick();
      tick();
      chk("full_in_ready_held", in_ready, 0);
      start_job(1, 1, 5, 2, 1);
      k = 0;
      while (!in_ready && k < 50) begin
         tick();
         k++;
      end
      chk("ninth_accept_cycles", k, 3);
      tick();
      in_valid = 1'b0;
      wait_idle();
      start_job(8, 11, 12, 9, 1);
      wait_idle();

      // Reset in STREAM aborts the job and flushes queued operands.
      push(2, 3); push(4, 5); push(1, 7);
      start = 1'b1; len = 3;
      tick();
      start = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      chk("midrst_in_ready", in_ready, 0);
      tick();
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_result", result, 0);
      rst_n = 1'b1;
      tick();
      push(5, 5);
      start_job(1, 25, -1, 2, 1);
      wait_idle();
      repeat (5) tick();
      chk("scoreboard_drained", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mac_feeder.md
MAC_FEEDER -- requirements
Module: mac_feeder

Interface
REQ-001 Parameter DATA_WIDTH, default 8, operand width; result width is 3*DATA_WIDTH.
REQ-002 Parameter DEPTH, default 8, operand FIFO depth in entries (power of two, >=2).
REQ-003 Parameter LEN_WIDTH, default 8, width of the job-length input and element counter.
REQ-004 The block SHALL use one clock; reset is synchronous and active-low: clk, rst_n.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst_n  in  1  synchronous active-low reset.
REQ-007 start  in  1  job request, sampled only in IDLE.
REQ-008 len  in  LEN_WIDTH  operand-pair count for the job, sampled with start.
REQ-009 in_valid / in_ready / in_a / in_b  in/out/in/in  1/1/DATA_WIDTH/DATA_WIDTH  operand-pair stream, valid/ready handshake.
REQ-010 mac_en / mac_clr  out  1/1  drive En/Clr of the downstream MAC.
REQ-011 mac_a / mac_b  out  DATA_WIDTH each  drive Ain/Bin of the downstream MAC.
REQ-012 mac_cout  in  3*DATA_WIDTH  Cout from the downstream MAC.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  one-cycle pulse, result valid.
REQ-015 result  out  3*DATA_WIDTH  captured dot product, held until next done.

Function
REQ-016 Operand FIFO: push on in_valid && in_ready; in_ready = !full; no bypass when full; accepts pushes in every state, including IDLE.
REQ-017 FIFO pointers SHALL wrap modulo DEPTH; a simultaneous push and pop when neither full nor empty leaves occupancy unchanged.
REQ-018 States: IDLE, CLEAR, PRIME, STREAM, DRAIN, DONE.
REQ-019 IDLE: on start with len!=0, latch len, zero the element count, go to CLEAR.
REQ-019a IDLE: on start with len==0, load result=0 and go to DONE; the MAC is not touched.
REQ-020 CLEAR: mac_clr=1 and mac_en=0 for exactly one cycle, then go to PRIME.
REQ-021 PRIME: while the FIFO is empty, mac_en=0; otherwise mac_en=1 with no pop, then go to STREAM. This cycle moves the MAC into its accumulate state.
REQ-022 STREAM, FIFO non-empty: pop, drive the head entry onto mac_a/mac_b, mac_en=1, increment the count. The MAC accumulates the product at that edge.
REQ-023 STREAM, FIFO empty: mac_en=0, no pop, go to PRIME. The MAC returns to idle and must be re-primed.
REQ-024 STREAM: the pop that brings the count to len goes to DRAIN.
REQ-025 DRAIN: mac_en=0; capture result <= mac_cout; go to DONE.
REQ-026 DONE: done=1 for one cycle; go to IDLE.
REQ-027 start outside IDLE SHALL be ignored; len changes outside IDLE have no effect.
REQ-028 Operands beyond len remain in the FIFO for the next job.
REQ-029 mac_a/mac_b SHALL be 0 whenever mac_en=0 or in PRIME.
REQ-030 mac_clr SHALL be 0 in all states except CLEAR.
REQ-031 Latency with the FIFO pre-filled: start edge, then CLEAR, PRIME, len STREAM cycles, DRAIN, then done. done is high in cycle len+4 after start is sampled.
REQ-032 The count SHALL be LEN_WIDTH bits and SHALL NOT wrap; len = 2^LEN_WIDTH-1 is supported.

Reset
REQ-033 When rst_n=0 at a clock edge, the block SHALL go to IDLE and empty the FIFO.
REQ-033a On that reset edge the count and result SHALL be cleared to 0.
REQ-033b On that reset edge busy, done, mac_en and mac_clr SHALL go to 0, and mac_a and mac_b SHALL go to 0.
REQ-033c While rst_n=0, in_ready SHALL be 0.
REQ-034 Reset mid-job (any state) SHALL abort the job with no done pulse; queued operands are discarded.

Verification
REQ-035 FIFO holds (2,3),(4,5),(1,7); start, len=3 -> mac_clr once, prime, 3 pops; done at cycle 7 with result=33.
REQ-036 len=3; pairs (2,3),(4,5), then a 2-cycle gap, then (1,7) -> mac_en low during the gap, PRIME re-entered; result=33.
REQ-037 start with len=0 -> done on the next cycle, result=0, mac_en and mac_clr never asserted.
REQ-038 DEPTH=8, 9 pairs offered in IDLE -> in_ready low after 8 accepts; 9th accepted after the first pop.
REQ-039 len=4, all pairs (255,255) -> result=260100; then len=1 with (3,3) -> result=9, confirming mac_clr between jobs.
REQ-040 rst_n low during STREAM -> next cycle IDLE, FIFO empty, busy=0, result=0, no done pulse.
